simd_host_loader: RTL and testbench

Parametrised host-side loader/unloader for the SIMD datapath. It accepts commands plus a DATA_WIDTH-wide word stream from the PS and packs the words into PE_COUNT-lane rows for BRAM A/B, or into INS_WIDTH instructions for BRAM INS. It also reads result rows back from BRAM R and serialises them onto an output stream. It sits between the PS interconnect and the `datapath_top` BRAM ports, replacing direct per-row PS writes.

---
 rtl/simd_host_loader_if.sv | 29 ++
 rtl/simd_host_loader.sv | 172 +++++++++++++++++
 tb/tb_simd_host_loader.sv | 367 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/simd_host_loader_if.sv
// Host-side bundle for simd_host_loader: command channel, load word stream and readback word stream.
interface simd_host_loader_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 10
);
   logic                  cmd_valid;
   logic                  cmd_ready;
   logic [1:0]            cmd_op;
   logic [ADDR_WIDTH-1:0] cmd_addr;
   logic [ADDR_WIDTH:0]   cmd_len;
   logic                  s_valid;
   logic                  s_ready;
   logic [DATA_WIDTH-1:0] s_data;
   logic                  s_last;
   logic                  m_valid;
   logic                  m_ready;
   logic [DATA_WIDTH-1:0] m_data;
   logic                  m_last;

   modport master (
      output cmd_valid, cmd_op, cmd_addr, cmd_len, s_valid, s_data, s_last, m_ready,
      input  cmd_ready, s_ready, m_valid, m_data, m_last
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_addr, cmd_len, s_valid, s_data, s_last, m_ready,
      output cmd_ready, s_ready, m_valid, m_data, m_last
   );
endinterface

// File: rtl/simd_host_loader.sv
// Packs PS stream words into BRAM A/B rows or INS words, and serialises BRAM R rows back out.
// Optional macro SIMD_LOADER_PAD_EN: an early s_last zero-fills and writes the partial unit.
module simd_host_loader #(
   parameter int PE_COUNT       = 8,
   parameter int DATA_WIDTH     = 32,
   parameter int BRAM_DEPTH     = 1024,
   parameter int ADDR_WIDTH     = $clog2(BRAM_DEPTH),
   parameter int INS_ADDR_WIDTH = 10,
   parameter int INS_WIDTH      = 64
) (
   input  logic                           clk,
   input  logic                           rstn,
   simd_host_loader_if.slave              host,
   output logic                           bram_a_wr_en,
   output logic [ADDR_WIDTH-1:0]          bram_a_wr_addr,
   output logic [PE_COUNT*DATA_WIDTH-1:0] bram_a_wr_data,
   output logic                           bram_b_wr_en,
   output logic [ADDR_WIDTH-1:0]          bram_b_wr_addr,
   output logic [PE_COUNT*DATA_WIDTH-1:0] bram_b_wr_data,
   output logic                           bram_ins_wr_en,
   output logic [INS_ADDR_WIDTH-1:0]      bram_ins_wr_addr,
   output logic [INS_WIDTH-1:0]           bram_ins_wr_data,
   output logic [ADDR_WIDTH-1:0]          bram_r_r_addr,
   input  logic [PE_COUNT*DATA_WIDTH-1:0] bram_r_r_data,
   output logic                           busy,
   output logic                           err
);
   localparam int INS_WORDS = INS_WIDTH / DATA_WIDTH;
   localparam int LANES     = (PE_COUNT > INS_WORDS) ? PE_COUNT : INS_WORDS;
   localparam int LANE_W    = $clog2(LANES);
   localparam logic [ADDR_WIDTH-1:0] LAST_ROW = ADDR_WIDTH'(BRAM_DEPTH - 1);
   localparam logic [ADDR_WIDTH:0]   ONE_UNIT = 1;

   typedef enum logic [2:0] {IDLE, LOAD, WRITE, RD_REQ, RD_WAIT, RD_EMIT} state_t;

   state_t                    state;
   logic [1:0]                op;
   logic [ADDR_WIDTH-1:0]     addr;
   logic [INS_ADDR_WIDTH-1:0] ins_addr;
   logic [ADDR_WIDTH:0]       units_left;
   logic [LANE_W-1:0]         lane;
   logic                      stop;
   logic [DATA_WIDTH-1:0]     pack  [LANES];
   logic [DATA_WIDTH-1:0]     shift [PE_COUNT];
   logic                      unit_end;
   logic                      final_unit;
   logic [ADDR_WIDTH-1:0]     next_row;

   assign unit_end   = lane == ((op == 2'd2) ? LANE_W'(INS_WORDS - 1) : LANE_W'(PE_COUNT - 1));
   assign final_unit = units_left == ONE_UNIT;
   assign next_row   = (addr == LAST_ROW) ? '0 : addr + 1'b1;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state      <= IDLE;
         op         <= '0;
         addr       <= '0;
         ins_addr   <= '0;
         units_left <= '0;
         lane       <= '0;
         stop       <= 1'b0;
         err        <= 1'b0;
         for (int j = 0; j < LANES; j++) pack[j] <= '0;
         for (int i = 0; i < PE_COUNT; i++) shift[i] <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (host.cmd_valid) begin
                  op         <= host.cmd_op;
                  addr       <= host.cmd_addr;
                  ins_addr   <= INS_ADDR_WIDTH'(host.cmd_addr);
                  units_left <= host.cmd_len;
                  lane       <= '0;
                  stop       <= 1'b0;
                  err        <= 1'b0;
                  if (host.cmd_len != '0)
                     state <= (host.cmd_op == 2'd3) ? RD_REQ : LOAD;
               end
            end
            LOAD: begin
               if (host.s_valid) begin
                  for (int j = 0; j < LANES; j++) begin
                     if (LANE_W'(j) == lane)
                        pack[j] <= host.s_data;
`ifdef SIMD_LOADER_PAD_EN
                     else if (host.s_last && (LANE_W'(j) > lane))
                        pack[j] <= '0;
`endif
                  end
                  lane <= lane + 1'b1;
                  if (unit_end) begin
                     lane  <= '0;
                     state <= WRITE;
                     if (final_unit && !host.s_last)
                        err <= 1'b1;
                     if (!final_unit && host.s_last) begin
                        stop <= 1'b1;
`ifndef SIMD_LOADER_PAD_EN
                        err  <= 1'b1;
`endif
                     end
                  end else if (host.s_last) begin
                     lane <= '0;
`ifdef SIMD_LOADER_PAD_EN
                     stop  <= 1'b1;
                     state <= WRITE;
`else
                     err   <= 1'b1;
                     state <= IDLE;
`endif
                  end
               end
            end
            WRITE: begin
               if (op == 2'd2)
                  ins_addr <= ins_addr + 1'b1;
               else
                  addr <= next_row;
               units_left <= units_left - 1'b1;
               state      <= (stop || final_unit) ? IDLE : LOAD;
            end
            RD_REQ: state <= RD_WAIT;
            RD_WAIT: begin
               for (int i = 0; i < PE_COUNT; i++)
                  shift[i] <= bram_r_r_data[i*DATA_WIDTH +: DATA_WIDTH];
               lane  <= '0;
               state <= RD_EMIT;
            end
            RD_EMIT: begin
               // Shifting only on a handshake keeps m_data frozen through backpressure.
               if (host.m_ready) begin
                  for (int i = 0; i < PE_COUNT - 1; i++) shift[i] <= shift[i+1];
                  shift[PE_COUNT-1] <= '0;
                  if (lane == LANE_W'(PE_COUNT - 1)) begin
                     lane       <= '0;
                     addr       <= next_row;
                     units_left <= units_left - 1'b1;
                     state      <= final_unit ? IDLE : RD_REQ;
                  end else begin
                     lane <= lane + 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign host.cmd_ready = (state == IDLE);
   assign host.s_ready   = (state == LOAD);
   assign host.m_valid   = (state == RD_EMIT);
   assign host.m_data    = shift[0];
   assign host.m_last    = (state == RD_EMIT) && (lane == LANE_W'(PE_COUNT - 1)) && final_unit;
   assign busy           = (state != IDLE);

   assign bram_a_wr_en     = (state == WRITE) && (op == 2'd0);
   assign bram_b_wr_en     = (state == WRITE) && (op == 2'd1);
   assign bram_ins_wr_en   = (state == WRITE) && (op == 2'd2);
   assign bram_a_wr_addr   = addr;
   assign bram_b_wr_addr   = addr;
   assign bram_ins_wr_addr = ins_addr;
   assign bram_r_r_addr    = addr;

   for (genvar g = 0; g < PE_COUNT; g++) begin : g_row
      assign bram_a_wr_data[g*DATA_WIDTH +: DATA_WIDTH] = pack[g];
      assign bram_b_wr_data[g*DATA_WIDTH +: DATA_WIDTH] = pack[g];
   end

   for (genvar g = 0; g < INS_WORDS; g++) begin : g_ins
      assign bram_ins_wr_data[g*DATA_WIDTH +: DATA_WIDTH] = pack[g];
   end
endmodule

// File: tb/tb_simd_host_loader.sv
// Directed self-checking bench for simd_host_loader; follows SIMD_LOADER_PAD_EN for the early-s_last case.
module tb_simd_host_loader;
   localparam int PE    = 8;
   localparam int DW    = 32;
   localparam int DEPTH = 1024;
   localparam int AW    = 10;
   localparam int IAW   = 10;
   localparam int IW    = 64;
   localparam int RW    = PE * DW;

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   int   cyc  = 0;
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   simd_host_loader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) host ();

   logic           a_en, b_en, i_en, busy, err;
   logic [AW-1:0]  a_addr, b_addr, r_addr;
   logic [RW-1:0]  a_data, b_data, r_data;
   logic [IAW-1:0] i_addr;
   logic [IW-1:0]  i_data;
   logic [RW-1:0]  r_mem [DEPTH];

   simd_host_loader #(
      .PE_COUNT(PE), .DATA_WIDTH(DW), .BRAM_DEPTH(DEPTH), .ADDR_WIDTH(AW),
      .INS_ADDR_WIDTH(IAW), .INS_WIDTH(IW)
   ) dut (
      .clk(clk), .rstn(rstn), .host(host),
      .bram_a_wr_en(a_en), .bram_a_wr_addr(a_addr), .bram_a_wr_data(a_data),
      .bram_b_wr_en(b_en), .bram_b_wr_addr(b_addr), .bram_b_wr_data(b_data),
      .bram_ins_wr_en(i_en), .bram_ins_wr_addr(i_addr), .bram_ins_wr_data(i_data),
      .bram_r_r_addr(r_addr), .bram_r_r_data(r_data),
      .busy(busy), .err(err)
   );

   // One-cycle-latency model of BRAM R.
   always @(posedge clk) r_data <= r_mem[r_addr];

   logic [AW-1:0]  a_addr_q[$], b_addr_q[$];
   logic [RW-1:0]  a_data_q[$], b_data_q[$];
   logic [IAW-1:0] i_addr_q[$];
   logic [IW-1:0]  i_data_q[$];
   int             a_cyc_q[$];

   always @(negedge clk) begin
      if (a_en) begin a_addr_q.push_back(a_addr); a_data_q.push_back(a_data); a_cyc_q.push_back(cyc); end
      if (b_en) begin b_addr_q.push_back(b_addr); b_data_q.push_back(b_data); end
      if (i_en) begin i_addr_q.push_back(i_addr); i_data_q.push_back(i_data); end
   end

   function automatic logic [9:0] out_flags();
      return {host.cmd_ready, host.s_ready, host.m_valid, host.m_last, busy, err,
              a_en, b_en, i_en, (host.m_data != '0)};
   endfunction

   task automatic clear_logs();
      a_addr_q.delete(); a_data_q.delete(); a_cyc_q.delete();
      b_addr_q.delete(); b_data_q.delete();
      i_addr_q.delete(); i_data_q.delete();
   endtask

   task automatic send_cmd(input logic [1:0] op, input logic [AW-1:0] addr,
                           input logic [AW:0] len, output int acc);
      int n = 0;
      host.cmd_valid = 1'b1; host.cmd_op = op; host.cmd_addr = addr; host.cmd_len = len;
      while (!host.cmd_ready && n < 50) begin @(posedge clk); #1; n++; end
      if (!host.cmd_ready) begin
         tests++; fails++;
         $display("[TB] FAIL cmd_accept_timeout: cmd_ready got %b required 1", host.cmd_ready);
      end
      acc = cyc;
      @(posedge clk); #1;
      host.cmd_valid = 1'b0;
   endtask

   task automatic send_word(input logic [DW-1:0] data, input logic last, output int hs);
      int n = 0;
      host.s_valid = 1'b1; host.s_data = data; host.s_last = last;
      while (!host.s_ready && n < 50) begin @(posedge clk); #1; n++; end
      if (!host.s_ready) begin
         tests++; fails++;
         $display("[TB] FAIL s_ready_timeout: s_ready got %b required 1", host.s_ready);
      end
      hs = cyc;
      @(posedge clk); #1;
      host.s_valid = 1'b0; host.s_last = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 200) begin @(posedge clk); #1; n++; end
      tests++;
      if (busy !== 1'b0) begin
         fails++;
         $display("[TB] FAIL idle_timeout: busy got %b required 0", busy);
      end
   endtask

   task automatic test_reset();
      #23;
      tests++;
      if (out_flags() !== 10'b10_0000_0000) begin
         fails++; $display("[TB] FAIL reset_flags: got %b required %b", out_flags(), 10'b1000000000);
      end
      tests++;
      if ({a_addr, i_addr, r_addr} !== '0) begin
         fails++; $display("[TB] FAIL reset_addrs: got %h required 0", {a_addr, i_addr, r_addr});
      end
      rstn = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_load_a();
      int acc, hs8, hs;
      logic [RW-1:0] e0, e1;
      clear_logs();
      send_cmd(2'd0, AW'(5), (AW+1)'(2), acc);
      hs8 = 0;
      for (int w = 1; w <= 16; w++) begin
         send_word(DW'(w), w == 16, hs);
         if (w == 8) hs8 = hs;
      end
      wait_idle();
      for (int i = 0; i < PE; i++) begin e0[i*DW +: DW] = DW'(i + 1); e1[i*DW +: DW] = DW'(i + 9); end
      tests++;
      if (a_addr_q.size() !== 2) begin
         fails++; $display("[TB] FAIL load_a_count: got %0d writes required 2", a_addr_q.size());
      end else begin
         tests++;
         if ({a_addr_q[0], a_addr_q[1]} !== {AW'(5), AW'(6)}) begin
            fails++; $display("[TB] FAIL load_a_addr: got %0d,%0d required 5,6", a_addr_q[0], a_addr_q[1]);
         end
         tests++;
         if (a_data_q[0] !== e0) begin fails++; $display("[TB] FAIL load_a_row0: got %h required %h", a_data_q[0], e0); end
         tests++;
         if (a_data_q[1] !== e1) begin fails++; $display("[TB] FAIL load_a_row1: got %h required %h", a_data_q[1], e1); end
         tests++;
         if (a_cyc_q[1] - a_cyc_q[0] !== 9) begin
            fails++; $display("[TB] FAIL load_a_stride: got %0d cycles required 9", a_cyc_q[1] - a_cyc_q[0]);
         end
         tests++;
         if (a_cyc_q[0] !== hs8 + 1) begin
            fails++; $display("[TB] FAIL load_a_wr_latency: got cycle %0d required %0d", a_cyc_q[0], hs8 + 1);
         end
      end
      tests++;
      if ({err, 8'(b_addr_q.size()), 8'(i_addr_q.size())} !== 17'd0) begin
         fails++; $display("[TB] FAIL load_a_side: err %b b %0d ins %0d required 0", err, b_addr_q.size(), i_addr_q.size());
      end
   endtask

   task automatic test_load_ins();
      int acc, hs;
      logic [DW-1:0] words [4];
      words = '{32'hA, 32'hB, 32'hC, 32'hD};
      clear_logs();
      send_cmd(2'd2, AW'(1023), (AW+1)'(2), acc);
      for (int w = 0; w < 4; w++) send_word(words[w], w == 3, hs);
      wait_idle();
      tests++;
      if (i_addr_q.size() !== 2) begin
         fails++; $display("[TB] FAIL load_ins_count: got %0d writes required 2", i_addr_q.size());
      end else begin
         tests++;
         if ({i_addr_q[0], i_addr_q[1]} !== {IAW'(1023), IAW'(0)}) begin
            fails++; $display("[TB] FAIL load_ins_addr: got %0d,%0d required 1023,0", i_addr_q[0], i_addr_q[1]);
         end
         tests++;
         if ({i_data_q[0], i_data_q[1]} !== {64'h0000000B_0000000A, 64'h0000000D_0000000C}) begin
            fails++; $display("[TB] FAIL load_ins_data: got %h,%h required 0000000b0000000a,0000000d0000000c", i_data_q[0], i_data_q[1]);
         end
      end
      tests++;
      if (err !== 1'b0) begin fails++; $display("[TB] FAIL load_ins_err: got %b required 0", err); end
   endtask

   task automatic test_read_r();
      int acc, first_cyc, cnt;
      logic [DW-1:0] got [PE];
      logic [PE-1:0] lastv;
      for (int i = 0; i < PE; i++) r_mem[3][i*DW +: DW] = DW'(100 + i);
      host.m_ready = 1'b1;
      send_cmd(2'd3, AW'(3), (AW+1)'(1), acc);
      cnt = 0; first_cyc = -1; lastv = '0;
      for (int n = 0; n < 40; n++) begin
         if (host.m_valid) begin
            if (first_cyc < 0) first_cyc = cyc;
            if (cnt < PE) begin got[cnt] = host.m_data; lastv[cnt] = host.m_last; end
            cnt++;
         end
         if (!busy && cnt > 0) break;
         @(posedge clk); #1;
      end
      tests++;
      if (cnt !== PE) begin fails++; $display("[TB] FAIL read_count: got %0d words required %0d", cnt, PE); end
      for (int i = 0; i < PE && i < cnt; i++) begin
         tests++;
         if (got[i] !== DW'(100 + i)) begin
            fails++; $display("[TB] FAIL read_word%0d: got %0d required %0d", i, got[i], 100 + i);
         end
      end
      tests++;
      if (lastv !== 8'h80) begin fails++; $display("[TB] FAIL read_m_last: got %b required 10000000", lastv); end
      tests++;
      if (first_cyc !== acc + 3) begin
         fails++; $display("[TB] FAIL read_latency: got %0d cycles required 3", first_cyc - acc);
      end
   endtask

   task automatic test_back_to_back_backpressure();
      int acc, cnt;
      logic stalled;
      logic [DW-1:0] held;
      logic [DW-1:0] got [PE];
      logic [PE-1:0] lastv;
      for (int i = 0; i < PE; i++) r_mem[4][i*DW +: DW] = DW'(200 + i);
      host.m_ready = 1'b0;
      send_cmd(2'd3, AW'(4), (AW+1)'(1), acc);
      cnt = 0; stalled = 1'b0; held = '0; lastv = '0;
      for (int n = 0; n < 80; n++) begin
         host.m_ready = (n % 2) == 1;
         if (host.m_valid && stalled) begin
            tests++;
            if (host.m_data !== held) begin
               fails++; $display("[TB] FAIL bp_hold: got %0d required %0d", host.m_data, held);
            end
         end
         if (host.m_valid && host.m_ready) begin
            if (cnt < PE) begin got[cnt] = host.m_data; lastv[cnt] = host.m_last; end
            cnt++;
         end
         stalled = host.m_valid && !host.m_ready;
         held = host.m_data;
         if (!busy && cnt > 0) break;
         @(posedge clk); #1;
      end
      host.m_ready = 1'b1;
      tests++;
      if (cnt !== PE) begin fails++; $display("[TB] FAIL bp_count: got %0d words required %0d", cnt, PE); end
      for (int i = 0; i < PE && i < cnt; i++) begin
         tests++;
         if (got[i] !== DW'(200 + i)) begin
            fails++; $display("[TB] FAIL bp_word%0d: got %0d required %0d", i, got[i], 200 + i);
         end
      end
      tests++;
      if (lastv !== 8'h80) begin fails++; $display("[TB] FAIL bp_m_last: got %b required 10000000", lastv); end
   endtask

   task automatic test_early_last();
      int acc, hs;
      logic [RW-1:0] exp_row;
      clear_logs();
      send_cmd(2'd1, AW'(7), (AW+1)'(1), acc);
      send_word(32'h11, 1'b0, hs);
      send_word(32'h22, 1'b0, hs);
      send_word(32'h33, 1'b1, hs);
      wait_idle();
      exp_row = '0;
      exp_row[0 +: DW] = 32'h11; exp_row[DW +: DW] = 32'h22; exp_row[2*DW +: DW] = 32'h33;
`ifdef SIMD_LOADER_PAD_EN
      tests++;
      if (b_addr_q.size() !== 1) begin
         fails++; $display("[TB] FAIL early_pad_count: got %0d writes required 1", b_addr_q.size());
      end else begin
         tests++;
         if ({b_addr_q[0], b_data_q[0]} !== {AW'(7), exp_row}) begin
            fails++; $display("[TB] FAIL early_pad_row: got addr %0d data %h required addr 7 data %h", b_addr_q[0], b_data_q[0], exp_row);
         end
      end
      tests++;
      if (err !== 1'b0) begin fails++; $display("[TB] FAIL early_pad_err: got %b required 0", err); end
`else
      tests++;
      if (b_addr_q.size() !== 0) begin
         fails++; $display("[TB] FAIL early_drop_count: got %0d writes required 0 (row %h)", b_addr_q.size(), exp_row);
      end
      tests++;
      if (err !== 1'b1) begin fails++; $display("[TB] FAIL early_drop_err: got %b required 1", err); end
`endif
   endtask

   task automatic test_missing_last();
      int acc, hs;
      clear_logs();
      send_cmd(2'd0, AW'(20), (AW+1)'(1), acc);
      for (int w = 0; w < PE; w++) send_word(DW'(32'h100 + w), 1'b0, hs);
      wait_idle();
      tests++;
      if (a_addr_q.size() !== 1) begin
         fails++; $display("[TB] FAIL missing_last_count: got %0d writes required 1", a_addr_q.size());
      end else begin
         tests++;
         if (a_addr_q[0] !== AW'(20)) begin
            fails++; $display("[TB] FAIL missing_last_addr: got %0d required 20", a_addr_q[0]);
         end
      end
      tests++;
      if (err !== 1'b1) begin fails++; $display("[TB] FAIL missing_last_err: got %b required 1", err); end
   endtask

   task automatic test_len_zero();
      int acc;
      clear_logs();
      send_cmd(2'd0, AW'(0), (AW+1)'(0), acc);
      repeat (2) begin @(posedge clk); #1; end
      tests++;
      if ({host.cmd_ready, busy, err} !== 3'b100) begin
         fails++; $display("[TB] FAIL len_zero_state: got %b required 100", {host.cmd_ready, busy, err});
      end
      tests++;
      if (a_addr_q.size() !== 0) begin
         fails++; $display("[TB] FAIL len_zero_writes: got %0d required 0", a_addr_q.size());
      end
   endtask

   task automatic test_reset_mid_load();
      int acc, hs;
      clear_logs();
      send_cmd(2'd0, AW'(9), (AW+1)'(1), acc);
      for (int w = 0; w < 4; w++) send_word(DW'(w + 50), 1'b0, hs);
      #2 rstn = 1'b0;
      #1;
      tests++;
      if (out_flags() !== 10'b10_0000_0000) begin
         fails++; $display("[TB] FAIL mid_reset_flags: got %b required %b", out_flags(), 10'b1000000000);
      end
      #10 rstn = 1'b1;
      @(posedge clk); #1;
      tests++;
      if ({host.cmd_ready, busy} !== 2'b10) begin
         fails++; $display("[TB] FAIL mid_reset_release: got %b required 10", {host.cmd_ready, busy});
      end
      repeat (3) begin @(posedge clk); #1; end
      tests++;
      if (a_addr_q.size() !== 0) begin
         fails++; $display("[TB] FAIL mid_reset_writes: got %0d required 0", a_addr_q.size());
      end
   endtask

   initial begin
      host.cmd_valid = 1'b0; host.cmd_op = '0; host.cmd_addr = '0; host.cmd_len = '0;
      host.s_valid = 1'b0; host.s_data = '0; host.s_last = 1'b0; host.m_ready = 1'b0;
      test_reset();
      test_load_a();
      test_load_ins();
      test_read_r();
      test_back_to_back_backpressure();
      test_early_last();
      test_missing_last();
      test_len_zero();
      test_reset_mid_load();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end
endmodule
